// File: rtl/sm83_timer.sv
// DMG timer block (DIV/TIMA/TMA/TAC) decoded on the CPU bus, with a one-clock timer irq.
// Define SM83_TIMER_RELOAD_DELAY_EN for the DMG-accurate four-clock delayed TIMA reload.
module sm83_timer #(
    parameter logic [15:0] BASE_ADDR   = 16'hFF04,
    parameter logic [15:0] SYSCNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  w_data,
    input  logic        w_wen,
    output logic [7:0]  r_data,
    output logic        r_hit,
    output logic        irq
);

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 8;
    localparam int unsigned TW  = 3;

    logic [AW-1:0] offset;
    logic          wr_en;
    logic          wr_div;
    logic          wr_tima;
    logic          wr_tma;
    logic          wr_tac;

    logic [AW-1:0] sysc_q, sysc_d;
    logic [DW-1:0] tima_q, tima_d;
    logic [DW-1:0] tma_q,  tma_d;
    logic [TW-1:0] tac_q,  tac_d;
    logic          tick_q, tick_d;
    logic          irq_q,  irq_d;

    logic          tap;
    logic          tick_sig;
    logic          fall;

    // Address decode; offset wraps so any BASE_ADDR alignment works.
    assign offset  = addr - BASE_ADDR;
    assign r_hit   = (offset[AW-1:2] == '0);
    assign wr_en   = w_wen & r_hit;
    assign wr_div  = wr_en & (offset[1:0] == 2'd0);
    assign wr_tima = wr_en & (offset[1:0] == 2'd1);
    assign wr_tma  = wr_en & (offset[1:0] == 2'd2);
    assign wr_tac  = wr_en & (offset[1:0] == 2'd3);

    always_comb begin
        r_data = '0;
        if (r_hit) begin
            case (offset[1:0])
                2'd0:    r_data = sysc_q[AW-1:DW];
                2'd1:    r_data = tima_q;
                2'd2:    r_data = tma_q;
                default: r_data = {5'b11111, tac_q};
            endcase
        end
    end

    // Frequency tap; TIMA counts on the falling edge of the gated tap.
    always_comb begin
        case (tac_q[1:0])
            2'd0:    tap = sysc_q[9];
            2'd1:    tap = sysc_q[3];
            2'd2:    tap = sysc_q[5];
            default: tap = sysc_q[7];
        endcase
    end

    assign tick_sig = tac_q[2] & tap;
    assign fall     = tick_q & ~tick_sig;
    assign tick_d   = tick_sig;
    assign sysc_d   = wr_div ? '0 : AW'(sysc_q + AW'(1));
    assign tma_d    = wr_tma ? w_data : tma_q;
    assign tac_d    = wr_tac ? w_data[TW-1:0] : tac_q;

`ifdef SM83_TIMER_RELOAD_DELAY_EN
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q,   cnt_d;
    logic       overflow;
    logic       reload;

    assign overflow = (state_q == S_IDLE) & fall & ~wr_tima & (tima_q == 8'hFF);
    assign reload   = (state_q == S_WAIT) & (cnt_q == 2'd0) & ~wr_tima;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A TIMA write during the wait abandons the pending reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (overflow) begin
                    state_d = S_WAIT;
                    cnt_d   = 2'd3;
                end
            end
            default: begin
                if (wr_tima || (cnt_q == 2'd0)) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = 2'(cnt_q - 2'd1);
                end
            end
        endcase
    end

    always_comb begin
        tima_d = tima_q;
        irq_d  = 1'b0;
        if (wr_tima) begin
            tima_d = w_data;
        end else if (reload) begin
            tima_d = tma_d;
            irq_d  = 1'b1;
        end else if (fall) begin
            tima_d = DW'(tima_q + DW'(1));
        end
    end
`else
    // Immediate reload: overflow loads TMA on the same edge.
    always_comb begin
        tima_d = tima_q;
        irq_d  = 1'b0;
        if (wr_tima) begin
            tima_d = w_data;
        end else if (fall) begin
            if (tima_q == 8'hFF) begin
                tima_d = tma_d;
                irq_d  = 1'b1;
            end else begin
                tima_d = DW'(tima_q + DW'(1));
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sysc_q <= SYSCNT_INIT;
            tima_q <= '0;
            tma_q  <= '0;
            tac_q  <= '0;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            sysc_q <= sysc_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            tick_q <= tick_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_sm83_timer.sv
// Bench for sm83_timer: register-map vector table, a cycle model feeding a scoreboard,
// and directed sequences for tick edges, overflow/reload and write priority.
module tb_sm83_timer;

    localparam logic [15:0] BASE = 16'hFF04;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  w_data = 8'h00;
    logic        w_wen = 1'b0;
    logic [7:0]  r_data;
    logic        r_hit;
    logic        irq;

    sm83_timer #(
        .BASE_ADDR  (BASE),
        .SYSCNT_INIT(16'h0000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .w_data(w_data),
        .w_wen (w_wen),
        .r_data(r_data),
        .r_hit (r_hit),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic [7:0] data;
        logic       irq;
    } obs_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        hit;
        logic [7:0]  data;
    } vec_t;

    obs_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference timer state
    logic [15:0] m_sysc;
    logic [7:0]  m_tima;
    logic [7:0]  m_tma;
    logic [2:0]  m_tac;
    logic        m_tick;
    logic        m_irq;
    int          m_wait;

    task automatic model_reset();
        m_sysc = 16'h0000;
        m_tima = 8'h00;
        m_tma  = 8'h00;
        m_tac  = 3'b000;
        m_tick = 1'b0;
        m_irq  = 1'b0;
        m_wait = -1;
    endtask

    function automatic obs_t model_obs(input logic [15:0] a);
        obs_t        o;
        logic [15:0] off;
        off    = a - BASE;
        o.hit  = (off < 16'd4);
        o.data = 8'h00;
        o.irq  = m_irq;
        if (o.hit) begin
            if (off == 16'd0)      o.data = m_sysc[15:8];
            else if (off == 16'd1) o.data = m_tima;
            else if (off == 16'd2) o.data = m_tma;
            else                   o.data = {5'b11111, m_tac};
        end
        return o;
    endfunction

    task automatic model_step(input logic [15:0] a, input logic [7:0] d, input logic we);
        logic [15:0] off;
        logic        hit, tap, tick_now, fall, n_irq;
        logic [15:0] n_sysc;
        logic [7:0]  n_tima, n_tma;
        logic [2:0]  n_tac;
        int          n_wait;
        off = a - BASE;
        hit = we && (off < 16'd4);
        case (m_tac[1:0])
            2'd0:    tap = m_sysc[9];
            2'd1:    tap = m_sysc[3];
            2'd2:    tap = m_sysc[5];
            default: tap = m_sysc[7];
        endcase
        tick_now = m_tac[2] & tap;
        fall     = m_tick & ~tick_now;
        n_sysc = (hit && off == 16'd0) ? 16'h0000 : 16'(m_sysc + 16'd1);
        n_tma  = (hit && off == 16'd2) ? d : m_tma;
        n_tac  = (hit && off == 16'd3) ? d[2:0] : m_tac;
        n_tima = m_tima;
        n_irq  = 1'b0;
        n_wait = m_wait;
`ifdef SM83_TIMER_RELOAD_DELAY_EN
        if (hit && off == 16'd1) begin
            n_tima = d;
            n_wait = -1;
        end else if (m_wait == 0) begin
            n_tima = n_tma;
            n_irq  = 1'b1;
            n_wait = -1;
        end else begin
            if (m_wait > 0) n_wait = m_wait - 1;
            if (fall) begin
                if (m_tima == 8'hFF && m_wait < 0) begin
                    n_tima = 8'h00;
                    n_wait = 3;
                end else begin
                    n_tima = 8'(m_tima + 8'd1);
                end
            end
        end
`else
        if (hit && off == 16'd1) begin
            n_tima = d;
        end else if (fall) begin
            if (m_tima == 8'hFF) begin
                n_tima = n_tma;
                n_irq  = 1'b1;
            end else begin
                n_tima = 8'(m_tima + 8'd1);
            end
        end
`endif
        m_sysc = n_sysc;
        m_tima = n_tima;
        m_tma  = n_tma;
        m_tac  = n_tac;
        m_tick = tick_now;
        m_irq  = n_irq;
        m_wait = n_wait;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        w_wen  = 1'b0;
        addr   = 16'h0000;
        w_data = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sb_q.delete();
    endtask

    // One bus cycle: drive, queue the model's view, sample at negedge, advance model at posedge.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic we,
                        output logic [7:0] rd, output logic rh, output logic ri);
        obs_t e, o;
        addr   = a;
        w_data = d;
        w_wen  = we;
        sb_q.push_back(model_obs(a));
        @(negedge clk);
        o.hit  = r_hit;
        o.data = r_data;
        o.irq  = irq;
        e = sb_q.pop_front();
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL sb addr=%h: got hit=%b data=%h irq=%b, expected hit=%b data=%h irq=%b",
                     a, o.hit, o.data, o.irq, e.hit, e.data, e.irq);
        end
        rd = r_data;
        rh = r_hit;
        ri = irq;
        @(posedge clk);
        model_step(a, d, we);
        #1;
    endtask

    task automatic setup_ovf();
        logic [7:0] v;
        logic       h, q;
        do_reset();
        step(16'hFF06, 8'hAB, 1'b1, v, h, q);
        step(16'hFF05, 8'hFE, 1'b1, v, h, q);
        step(16'hFF07, 8'h05, 1'b1, v, h, q);
        step(16'hFF04, 8'h00, 1'b1, v, h, q);
    endtask

    initial begin
        vec_t       vt[18];
        logic [7:0] v;
        logic       h, q;
        logic [7:0] tv[0:47];
        logic       iv[0:47];
        int         irq_seen;

        vt[0]  = '{16'hFF04, 8'h00, 1'b0, 1'b1, 8'h00};
        vt[1]  = '{16'hFF05, 8'h00, 1'b0, 1'b1, 8'h00};
        vt[2]  = '{16'hFF06, 8'h00, 1'b0, 1'b1, 8'h00};
        vt[3]  = '{16'hFF07, 8'h00, 1'b0, 1'b1, 8'hF8};
        vt[4]  = '{16'hFF08, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[5]  = '{16'hFF03, 8'h00, 1'b0, 1'b0, 8'h00};
        vt[6]  = '{16'hFF06, 8'h5A, 1'b1, 1'b1, 8'h00};
        vt[7]  = '{16'hFF06, 8'h00, 1'b0, 1'b1, 8'h5A};
        vt[8]  = '{16'hFF07, 8'hFE, 1'b1, 1'b1, 8'hF8};
        vt[9]  = '{16'hFF07, 8'h00, 1'b0, 1'b1, 8'hFE};
        vt[10] = '{16'hFF08, 8'h33, 1'b1, 1'b0, 8'h00};
        vt[11] = '{16'hFF06, 8'h00, 1'b0, 1'b1, 8'h5A};
        vt[12] = '{16'hFF07, 8'h00, 1'b1, 1'b1, 8'hFE};
        vt[13] = '{16'hFF07, 8'h00, 1'b0, 1'b1, 8'hF8};
        vt[14] = '{16'hFF05, 8'hC3, 1'b1, 1'b1, 8'h00};
        vt[15] = '{16'hFF05, 8'h00, 1'b0, 1'b1, 8'hC3};
        vt[16] = '{16'h0000, 8'h99, 1'b1, 1'b0, 8'h00};
        vt[17] = '{16'hFF05, 8'h00, 1'b0, 1'b1, 8'hC3};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(vt[i].a, vt[i].d, vt[i].we, v, h, q);
            chk($sformatf("vec%0d data", i), 32'(v), 32'(vt[i].data));
            chk($sformatf("vec%0d hit", i), 32'(h), 32'(vt[i].hit));
        end

        // Enabled at sysc[3]: first count at 17, sixteenth at 257
        do_reset();
        step(16'hFF07, 8'h05, 1'b1, v, h, q);
        step(16'hFF05, 8'h00, 1'b1, v, h, q);
        step(16'hFF04, 8'h00, 1'b1, v, h, q);
        for (int k = 0; k <= 257; k++) begin
            step(16'hFF05, 8'h00, 1'b0, v, h, q);
            if (k == 16)  chk("tima before first tick", 32'(v), 32'h00);
            if (k == 17)  chk("tima first tick", 32'(v), 32'h01);
            if (k == 256) chk("tima before 16th tick", 32'(v), 32'h0F);
            if (k == 257) chk("tima 16 ticks", 32'(v), 32'h10);
        end

        // Overflow and reload of TMA=0xAB
        setup_ovf();
        for (int k = 0; k <= 40; k++) begin
            step(16'hFF05, 8'h00, 1'b0, tv[k], h, iv[k]);
        end
        chk("tima pre-overflow", 32'(tv[17]), 32'hFF);
        chk("tima at overflow clk", 32'(tv[32]), 32'hFF);
        chk("irq before reload", 32'(iv[32]), 32'h0);
`ifdef SM83_TIMER_RELOAD_DELAY_EN
        chk("tima wait0", 32'(tv[33]), 32'h00);
        chk("tima wait3", 32'(tv[36]), 32'h00);
        chk("tima reloaded", 32'(tv[37]), 32'hAB);
        chk("irq wait end", 32'(iv[36]), 32'h0);
        chk("irq pulse", 32'(iv[37]), 32'h1);
        chk("irq one clk", 32'(iv[38]), 32'h0);
`else
        chk("tima reloaded", 32'(tv[33]), 32'hAB);
        chk("irq pulse", 32'(iv[33]), 32'h1);
        chk("irq one clk", 32'(iv[34]), 32'h0);
`endif

`ifdef SM83_TIMER_RELOAD_DELAY_EN
        // TIMA write during the wait cancels reload and irq
        setup_ovf();
        irq_seen = 0;
        for (int k = 0; k <= 45; k++) begin
            if (k == 34) step(16'hFF05, 8'h42, 1'b1, v, h, q);
            else         step(16'hFF05, 8'h00, 1'b0, v, h, q);
            if (q) irq_seen++;
            if (k == 35) chk("cancel tima written", 32'(v), 32'h42);
            if (k == 40) chk("cancel no reload", 32'(v), 32'h42);
        end
        chk("cancel no irq", 32'(irq_seen), 32'h0);

        // Reset in the middle of the wait
        setup_ovf();
        for (int k = 0; k <= 33; k++) step(16'hFF05, 8'h00, 1'b0, v, h, q);
        do_reset();
        irq_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(16'hFF05, 8'h00, 1'b0, v, h, q);
            if (q) irq_seen++;
        end
        chk("reset mid-wait tima", 32'(v), 32'h00);
        chk("reset mid-wait irq", 32'(irq_seen), 32'h0);
`endif

        // DIV write while sysc[9]=1 counts once
        do_reset();
        step(16'hFF07, 8'h04, 1'b1, v, h, q);
        for (int k = 1; k < 16'h300; k++) step(16'hFF05, 8'h00, 1'b0, v, h, q);
        chk("div test tima before", 32'(v), 32'h00);
        step(16'hFF04, 8'h77, 1'b1, v, h, q);
        step(16'hFF04, 8'h00, 1'b0, v, h, q);
        chk("div cleared", 32'(v), 32'h00);
        for (int k = 1; k <= 20; k++) begin
            step(16'hFF05, 8'h00, 1'b0, v, h, q);
            if (k == 1)  chk("div clear tick", 32'(v), 32'h01);
            if (k == 20) chk("div clear tick once", 32'(v), 32'h01);
        end

        // Same-clk TIMA write beats the increment
        do_reset();
        step(16'hFF07, 8'h05, 1'b1, v, h, q);
        step(16'hFF04, 8'h00, 1'b1, v, h, q);
        for (int k = 0; k <= 33; k++) begin
            if (k == 16) step(16'hFF05, 8'h10, 1'b1, v, h, q);
            else         step(16'hFF05, 8'h00, 1'b0, v, h, q);
            if (k == 17) chk("write beats tick", 32'(v), 32'h10);
            if (k == 33) chk("next tick after write", 32'(v), 32'h11);
        end

        // Full DIV wrap with timer disabled
        step(16'hFF07, 8'h00, 1'b1, v, h, q);
        step(16'hFF04, 8'h00, 1'b1, v, h, q);
        irq_seen = 0;
        for (int k = 0; k <= 32'h10000; k++) begin
            step(16'hFF04, 8'h00, 1'b0, v, h, q);
            if (q) irq_seen++;
            if (k == 32'h00100) chk("div 0x01", 32'(v), 32'h01);
            if (k == 32'h0FFFF) chk("div 0xFF", 32'(v), 32'hFF);
            if (k == 32'h10000) chk("div wrap", 32'(v), 32'h00);
        end
        chk("no spurious irq", 32'(irq_seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sm83_timer.md
Name: sm83_timer

Overview:
- Memory-mapped DMG timer (DIV/TIMA/TMA/TAC) on the CPU data bus, next to ROM0/WRAM0 in the top-level decode.
- Consumes the CPU address, write-data and write-enable.
- Returns read data plus a hit flag, which the top-level read mux selects for 0xFF04–0xFF07.
- Produces a single-cycle timer interrupt request for the future interrupt controller.

Parameters:
- BASE_ADDR, 16'hFF04: address of DIV; TIMA/TMA/TAC follow at +1/+2/+3.
- SYSCNT_INIT, 16'h0000: reset value of the internal 16-bit system counter.

Ports:
- clk  in  1  system clock; one clk = one T-cycle (4.194304 MHz nominal)
- rst  in  1  synchronous, active-high reset
- addr  in  16  CPU bus address (shared r/w, as addr_out)
- w_data  in  8  CPU write data
- w_wen  in  1  CPU write strobe, one clk per write
- r_data  out  8  read data for addr; 0x00 when r_hit=0
- r_hit  out  1  addr within BASE_ADDR..BASE_ADDR+3 (combinational)
- irq  out  1  timer interrupt request, one-clk pulse

Behaviour:
- Reset (rst=1 at posedge): sysc=SYSCNT_INIT, TIMA=0, TMA=0, TAC=0, irq=0, delay state cleared. r_data/r_hit are combinational; after reset a read of TAC returns 0xF8.
- sysc: 16-bit counter, +1 every clk, wraps 0xFFFF->0x0000.
- DIV read = sysc[15:8].
- Any write to DIV sets sysc to 0x0000 on that clk; written data is ignored.
- Read map, combinational, zero latency:
  - DIV = sysc[15:8]
  - TIMA = tima
  - TMA = tma
  - TAC = {5'b11111, tac[2:0]}
- Writes to TIMA/TMA/TAC take effect at the posedge where w_wen=1; TAC stores w_data[2:0] only.
- Tap select by tac[1:0]: 00->sysc[9], 01->sysc[3], 10->sysc[5], 11->sysc[7].
- tick_sig = tac[2] & selected tap; tick_sig is registered as tick_q.
- TIMA increments on the clk where tick_q=1 and tick_sig=0 (falling edge). Consequences:
  - Clearing DIV while the tap is 1 produces an increment.
  - Disabling TAC while the tap is 1 produces an increment.
  - Changing the tap select from a 1-tap to a 0-tap produces an increment.
- Overflow: an increment with TIMA=0xFF wraps to 0x00 and triggers reload (timing per optional feature).
- Write priority on the same clk:
  - CPU write to TIMA beats a concurrent increment.
  - A reload uses the TMA value written on that same clk.
- irq is registered, high exactly one clk per reload, never asserted by writes alone.
- Writes when r_hit=0 are ignored; no side effects.

Optional Feature:
- Macro: SM83_TIMER_RELOAD_DELAY_EN
- Defined (DMG-accurate delayed reload):
  - On overflow TIMA holds 0x00 for 4 clks (state RELOAD_WAIT, 2-bit down-counter).
  - On the 4th clk TIMA<=TMA and irq pulses on the following clk.
  - A CPU write to TIMA during RELOAD_WAIT cancels the reload and irq; TIMA takes the written value.
  - Further falling edges during RELOAD_WAIT increment TIMA from 0x00 normally and do not cancel the reload.
  - States: IDLE -> RELOAD_WAIT (on overflow) -> IDLE (after 4 clks or a TIMA write).
  - Reset mid-wait returns to IDLE with no irq.
- Undefined:
  - Overflow loads TMA into TIMA on the same clk; irq pulses on the next clk.
  - No wait state; the TIMA-write cancel rule does not apply.

Test Plan:
- Reset, then read 0xFF04..0xFF07 -> r_hit=1, data 0x00,0x00,0x00,0xF8. Read 0xFF08 -> r_hit=0, r_data=0x00.
- TAC=0x05 (enable, sysc[3]), TIMA=0x00 -> TIMA=0x01 after 16 clks from a sysc=0 alignment, 0x10 after 256 clks.
- TMA=0xAB, TIMA=0xFE, TAC=0x05, run 32 clks:
  - Macro off: TIMA=0xAB at the second overflow edge, irq high one clk.
  - Macro on: TIMA=0x00 for 4 clks, then 0xAB, then irq pulse.
- Macro on: overflow, then write TIMA=0x42 two clks later -> TIMA=0x42, no irq, no TMA reload.
- TAC=0x04 (sysc[9]), run until sysc[9]=1, write DIV=0x77 -> sysc=0x0000, DIV reads 0x00, TIMA +1 exactly once.
- Same-clk write TIMA=0x10 coincident with a falling edge -> TIMA=0x10 (not 0x11). Run 0x10000 clks -> DIV wraps 0xFF->0x00 with no spurious irq when TAC=0x00.
